piso_serializer: RTL and testbench

Parallel-in serial-out shift register: the transmit-side counterpart to the parallel/serial capture registers on the board I/O path. Captures a parallel word on a load strobe and shifts it out one bit at a time, each bit held for a programmable number of clocks. Provides ready/busy/done status so a controller or debounced button can sequence words back-to-back.

---
 rtl/piso_serializer.sv | 158 +++++++++++++++
 tb/tb_piso_serializer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out shift register.
// Captures i_Data when i_Load is high in IDLE. The word is shifted out on
// o_Ser, and each bit is held for DIV clocks. After the last bit, the block
// spends one DONE cycle (o_Done pulse) and then returns to IDLE.
// Ports:
//   i_CLK   - system clock, rising edge
//   i_RST_N - asynchronous active-low reset
//   i_Data  - parallel word, sampled only on an accepted load
//   i_Load  - load strobe, level-sampled each rising edge
//   o_Ser   - registered serial data out
//   o_Busy  - high while bits are being shifted
//   o_Ready - high when a load will be accepted (IDLE)
//   o_Done  - one-cycle pulse after the last bit completes
module piso_serializer #(
  parameter int unsigned BUS_MSB   = 7,
  parameter int unsigned DIV       = 4,
  parameter int unsigned LSB_FIRST = 0
) (
  input  logic               i_CLK,
  input  logic               i_RST_N,
  input  logic [BUS_MSB:0]   i_Data,
  input  logic               i_Load,
  output logic               o_Ser,
  output logic               o_Busy,
  output logic               o_Ready,
  output logic               o_Done
);

  localparam int unsigned W     = BUS_MSB + 1;
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BIT_W = $clog2(W + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(W - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       r_state;
  logic [W-1:0]     r_shift;
  logic [DIV_W-1:0] r_div_cnt;
  logic [BIT_W-1:0] r_bit_cnt;
  logic             r_ser;
  logic             r_busy;
  logic             r_ready;
  logic             r_done;

  logic [1:0]       w_state_nxt;
  logic [W-1:0]     w_shift_nxt;
  logic [DIV_W-1:0] w_div_nxt;
  logic [BIT_W-1:0] w_bit_nxt;
  logic             w_ser_nxt;
  logic             w_busy_nxt;
  logic             w_ready_nxt;
  logic             w_done_nxt;

  // State and output registers
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
      r_ser     <= 1'b0;
      r_busy    <= 1'b0;
      r_ready   <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_div_cnt <= w_div_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_ser     <= w_ser_nxt;
      r_busy    <= w_busy_nxt;
      r_ready   <= w_ready_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_div_nxt   = r_div_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_ser_nxt   = r_ser;
    w_busy_nxt  = r_busy;
    w_ready_nxt = r_ready;
    w_done_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_ser_nxt   = 1'b0;
        w_busy_nxt  = 1'b0;
        w_ready_nxt = 1'b1;
        if (i_Load) begin
          w_state_nxt = S_SHIFT;
          w_busy_nxt  = 1'b1;
          w_ready_nxt = 1'b0;
          w_div_nxt   = '0;
          w_bit_nxt   = '0;
          // The first bit goes straight to o_Ser; the shift register keeps the rest.
          if (LSB_FIRST != 0) begin
            w_ser_nxt   = i_Data[0];
            w_shift_nxt = {1'b0, i_Data[W-1:1]};
          end else begin
            w_ser_nxt   = i_Data[W-1];
            w_shift_nxt = {i_Data[W-2:0], 1'b0};
          end
        end
      end

      S_SHIFT: begin
        if (r_div_cnt == DIV_LAST) begin
          w_div_nxt = '0;
          if (r_bit_cnt == BIT_LAST) begin
            w_state_nxt = S_DONE;
            w_ser_nxt   = 1'b0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_bit_nxt   = '0;
            w_shift_nxt = '0;
          end else begin
            w_bit_nxt = r_bit_cnt + BIT_W'(1);
            if (LSB_FIRST != 0) begin
              w_ser_nxt   = r_shift[0];
              w_shift_nxt = {1'b0, r_shift[W-1:1]};
            end else begin
              w_ser_nxt   = r_shift[W-1];
              w_shift_nxt = {r_shift[W-2:0], 1'b0};
            end
          end
        end else begin
          w_div_nxt = r_div_cnt + DIV_W'(1);
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_ready_nxt = 1'b1;
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_ser_nxt   = 1'b0;
        w_busy_nxt  = 1'b0;
        w_ready_nxt = 1'b1;
      end
    endcase
  end

  assign o_Ser   = r_ser;
  assign o_Busy  = r_busy;
  assign o_Ready = r_ready;
  assign o_Done  = r_done;

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: bench for piso_serializer with three instances.
//   u0: MSB first, DIV=4
//   u1: LSB first, DIV=4
//   u2: MSB first, DIV=1
// A timeline model predicts every output from the load edge and the elapsed
// clocks. Directed sequences also check literal serial words and pulse timing.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ld    [3];
  logic [7:0] dat   [3];
  logic       ser   [3];
  logic       busy  [3];
  logic       ready [3];
  logic       done  [3];

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  piso_serializer #(.BUS_MSB(7), .DIV(4), .LSB_FIRST(0)) u0 (
    .i_CLK(clk), .i_RST_N(rst_n), .i_Data(dat[0]), .i_Load(ld[0]),
    .o_Ser(ser[0]), .o_Busy(busy[0]), .o_Ready(ready[0]), .o_Done(done[0]));

  piso_serializer #(.BUS_MSB(7), .DIV(4), .LSB_FIRST(1)) u1 (
    .i_CLK(clk), .i_RST_N(rst_n), .i_Data(dat[1]), .i_Load(ld[1]),
    .o_Ser(ser[1]), .o_Busy(busy[1]), .o_Ready(ready[1]), .o_Done(done[1]));

  piso_serializer #(.BUS_MSB(7), .DIV(1), .LSB_FIRST(0)) u2 (
    .i_CLK(clk), .i_RST_N(rst_n), .i_Data(dat[2]), .i_Load(ld[2]),
    .o_Ser(ser[2]), .o_Busy(busy[2]), .o_Ready(ready[2]), .o_Done(done[2]));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int div_of(input int u);
    return (u == 2) ? 1 : 4;
  endfunction

  function automatic logic lsb_of(input int u);
    return (u == 1);
  endfunction

  // Timeline model: a word loaded at edge t0 shows bit k during edges
  // t0+k*DIV .. t0+(k+1)*DIV-1. It is done at t0+8*DIV, idle at t0+8*DIV+1,
  // and can reload from t0+8*DIV+2 onwards.
  int         cyc;
  logic       m_act [3];
  int         m_t0  [3];
  logic [7:0] m_dat [3];
  logic       e_ser [3];
  logic       e_busy [3];
  logic       e_ready [3];
  logic       e_done [3];

  initial begin
    int d;
    int j;
    int k;
    cyc = 0;
    for (int i = 0; i < 3; i++) begin
      m_act[i] = 1'b0; m_t0[i] = 0; m_dat[i] = '0;
      e_ser[i] = 1'b0; e_busy[i] = 1'b0; e_ready[i] = 1'b1; e_done[i] = 1'b0;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        cyc = 0;
        for (int i = 0; i < 3; i++) begin
          m_act[i] = 1'b0;
          e_ser[i] = 1'b0; e_busy[i] = 1'b0; e_ready[i] = 1'b1; e_done[i] = 1'b0;
        end
      end else begin
        cyc++;
        for (int i = 0; i < 3; i++) begin
          d = div_of(i);
          if ((!m_act[i] || (cyc - m_t0[i]) >= 8 * d + 2) && ld[i]) begin
            m_act[i] = 1'b1;
            m_t0[i]  = cyc;
            m_dat[i] = dat[i];
          end
          j = cyc - m_t0[i];
          if (m_act[i] && j < 8 * d) begin
            k = j / d;
            e_ser[i]   = lsb_of(i) ? m_dat[i][k] : m_dat[i][7-k];
            e_busy[i]  = 1'b1; e_ready[i] = 1'b0; e_done[i] = 1'b0;
          end else if (m_act[i] && j == 8 * d) begin
            e_ser[i]   = 1'b0; e_busy[i] = 1'b0; e_ready[i] = 1'b0; e_done[i] = 1'b1;
          end else begin
            e_ser[i]   = 1'b0; e_busy[i] = 1'b0; e_ready[i] = 1'b1; e_done[i] = 1'b0;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("u%0d_ser", i),   32'(ser[i]),   32'(e_ser[i]));
        chk($sformatf("u%0d_busy", i),  32'(busy[i]),  32'(e_busy[i]));
        chk($sformatf("u%0d_ready", i), 32'(ready[i]), 32'(e_ready[i]));
        chk($sformatf("u%0d_done", i),  32'(done[i]),  32'(e_done[i]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic collect(input int u, input int d, output logic [7:0] word);
    word = '0;
    for (int k = 0; k < 8; k++) begin
      word = {word[6:0], ser[u]};
      repeat (d) tick();
    end
  endtask

  initial begin
    logic [7:0]  w0;
    logic [7:0]  w1;
    logic [29:0] got_s;
    logic [29:0] exp_s;
    logic [9:0]  pat;
    int          ndone;

    for (int i = 0; i < 3; i++) begin
      ld[i] = 1'b0;
      dat[i] = '0;
    end

    // Reset and idle
    repeat (3) tick();
    chk("rst_ser", 32'(ser[0]), 32'd0);
    chk("rst_ready", 32'(ready[0]), 32'd1);
    chk("rst_busy", 32'(busy[2]), 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (20) tick();

    // MSB-first and LSB-first 8'h1E on the same edge
    dat[0] = 8'h1E; dat[1] = 8'h1E; ld[0] = 1'b1; ld[1] = 1'b1;
    tick();
    ld[0] = 1'b0; ld[1] = 1'b0;
    w0 = '0; w1 = '0;
    for (int k = 0; k < 8; k++) begin
      w0 = {w0[6:0], ser[0]};
      w1 = {w1[6:0], ser[1]};
      repeat (4) tick();
    end
    chk("msb_word_1E", 32'(w0), 32'h1E);
    chk("lsb_word_1E", 32'(w1), 32'h78);
    chk("msb_done_pulse", 32'(done[0]), 32'd1);
    chk("lsb_done_pulse", 32'(done[1]), 32'd1);
    chk("msb_ready_in_done", 32'(ready[0]), 32'd0);
    tick();
    chk("msb_ready_after", 32'(ready[0]), 32'd1);
    chk("msb_done_cleared", 32'(done[0]), 32'd0);
    repeat (3) tick();

    // 8'hA5 with ignored loads mid-word and in the DONE cycle
    dat[0] = 8'hA5; ld[0] = 1'b1;
    tick();
    ld[0] = 1'b0; dat[0] = 8'hFF;
    w0 = '0;
    for (int c = 0; c < 32; c++) begin
      if (c % 4 == 0) w0 = {w0[6:0], ser[0]};
      ld[0] = (c == 5 || c == 20);
      tick();
    end
    chk("ign_word_A5", 32'(w0), 32'hA5);
    chk("ign_done", 32'(done[0]), 32'd1);
    ld[0] = 1'b1;
    tick();
    ld[0] = 1'b0;
    chk("ign_no_restart_busy", 32'(busy[0]), 32'd0);
    chk("ign_ready", 32'(ready[0]), 32'd1);
    tick();
    chk("ign_still_idle", 32'(busy[0]), 32'd0);
    repeat (2) tick();

    // DIV=1 with held load: each 10-clock period is 1000000100
    dat[2] = 8'h81; ld[2] = 1'b1;
    tick();
    pat = 10'b0010000001;
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      got_s[i] = ser[2];
      exp_s[i] = pat[i % 10];
      if (done[2]) ndone++;
      tick();
    end
    ld[2] = 1'b0;
    chk("div1_stream", 32'(got_s), 32'(exp_s));
    chk("div1_done_count", 32'(ndone), 32'd3);
    repeat (12) tick();

    // Asynchronous reset during bit 3 of 8'hFF, then a fresh 8'h0F
    dat[0] = 8'hFF; ld[0] = 1'b1;
    tick();
    ld[0] = 1'b0;
    repeat (13) tick();
    chk("pre_rst_busy", 32'(busy[0]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_ser", 32'(ser[0]), 32'd0);
    chk("async_busy", 32'(busy[0]), 32'd0);
    chk("async_ready", 32'(ready[0]), 32'd1);
    chk("async_done", 32'(done[0]), 32'd0);
    repeat (2) tick();
    #2;
    rst_n = 1'b1;
    tick();
    dat[0] = 8'h0F; ld[0] = 1'b1;
    tick();
    ld[0] = 1'b0;
    collect(0, 4, w0);
    chk("post_rst_word_0F", 32'(w0), 32'h0F);
    repeat (4) tick();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
